// File: rtl/branch_add_scheduler_pkg.sv
// Shared types and defaults for the branch/add issue scheduler.
//   DEF_WIDTH / DEF_TAG_W / DEF_DEPTH : default datapath, tag and queue sizes
//   FUNC_W                            : branch compare function width
//   sched_ctrl_t                      : per-entry control record
//                                       (valid, op, func, pred)
// Operand value/tag/ready live in sched_operand_slot instances, and imm/pc
// live in per-entry arrays in the top. Keeping them outside this record
// means a top-level WIDTH or TAG_W override resizes them correctly.
package branch_add_scheduler_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_TAG_W = 5;
  localparam int DEF_DEPTH = 4;
  localparam int FUNC_W    = 3;

  typedef struct packed {
    logic              valid;
    logic              op;
    logic [FUNC_W-1:0] func;
    logic              pred;
  } sched_ctrl_t;

endpackage

// File: rtl/branch_add_scheduler_operand_slot.sv
// sched_operand_slot: one source operand of one queue entry.
//   i_load        : entry is being written by dispatch this cycle
//   i_entry_valid : owning entry currently holds a live op
//   i_val/i_tag/i_rdy : dispatch-side operand fields
//   i_cdb_*       : result broadcast bus
//   o_rdy/o_val   : operand usable this cycle; this includes a value being
//                   broadcast right now, so issue can forward it
module sched_operand_slot
  import branch_add_scheduler_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_entry_valid,
  input  logic [WIDTH-1:0] i_val,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_rdy,
  input  logic             i_cdb_valid,
  input  logic [TAG_W-1:0] i_cdb_tag,
  input  logic [WIDTH-1:0] i_cdb_data,
  output logic             o_rdy,
  output logic [WIDTH-1:0] o_val
);

  logic [WIDTH-1:0] val_q, val_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             rdy_q, rdy_d;
  logic             wake;
  logic             load_hit;

  always_comb begin
    wake     = i_entry_valid && !rdy_q && i_cdb_valid && (tag_q == i_cdb_tag);
    load_hit = i_cdb_valid && !i_rdy && (i_tag == i_cdb_tag);
    val_d    = val_q;
    tag_d    = tag_q;
    rdy_d    = rdy_q;
    if (i_load) begin
      tag_d = i_tag;
      if (load_hit) begin
        // Producer broadcasts in the same cycle the consumer dispatches.
        val_d = i_cdb_data;
        rdy_d = 1'b1;
      end else begin
        val_d = i_val;
        rdy_d = i_rdy;
      end
    end else if (wake) begin
      val_d = i_cdb_data;
      rdy_d = 1'b1;
    end
    o_rdy = rdy_q || wake;
    o_val = rdy_q ? val_q : i_cdb_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      val_q <= '0;
      tag_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      val_q <= val_d;
      tag_q <= tag_d;
      rdy_q <= rdy_d;
    end
  end

endmodule

// File: rtl/branch_add_scheduler.sv
// branch_add_scheduler: in-order issue queue feeding one branch/add unit.
//   Dispatch handshake: an op transfers on a rising edge where
//   i_disp_valid && o_disp_ready. o_disp_ready depends only on registered
//   occupancy and i_flush. It never depends on i_disp_valid.
//   Issue: o_start pulses for one cycle with the o_* fields of the issued op.
//   There is no back-pressure from the unit.
//   CDB: i_cdb_* wakes waiting operands and forwards into issue.
//   i_flush: drops every queued op on the edge where it is high.
//   o_count: number of occupied entries.
module branch_add_scheduler
  import branch_add_scheduler_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_disp_valid,
  output logic                       o_disp_ready,
  input  logic                       i_disp_op,
  input  logic [FUNC_W-1:0]          i_disp_func,
  input  logic [WIDTH-1:0]           i_disp_rs1_val,
  input  logic [WIDTH-1:0]           i_disp_rs2_val,
  input  logic [TAG_W-1:0]           i_disp_rs1_tag,
  input  logic [TAG_W-1:0]           i_disp_rs2_tag,
  input  logic                       i_disp_rs1_rdy,
  input  logic                       i_disp_rs2_rdy,
  input  logic [WIDTH-1:0]           i_disp_imm,
  input  logic [WIDTH-1:0]           i_disp_pc,
  input  logic                       i_disp_pred,
  input  logic                       i_cdb_valid,
  input  logic [TAG_W-1:0]           i_cdb_tag,
  input  logic [WIDTH-1:0]           i_cdb_data,
  input  logic                       i_flush,
  output logic                       o_start,
  output logic                       o_op,
  output logic [FUNC_W-1:0]          o_func,
  output logic [WIDTH-1:0]           o_rs1,
  output logic [WIDTH-1:0]           o_rs2,
  output logic [WIDTH-1:0]           o_imm,
  output logic [WIDTH-1:0]           o_pc,
  output logic                       o_pred,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sched_ctrl_t      ctrl_q [DEPTH];
  sched_ctrl_t      ctrl_d [DEPTH];
  logic [WIDTH-1:0] imm_q  [DEPTH];
  logic [WIDTH-1:0] imm_d  [DEPTH];
  logic [WIDTH-1:0] pc_q   [DEPTH];
  logic [WIDTH-1:0] pc_d   [DEPTH];
  logic             rs1_rdy [DEPTH];
  logic             rs2_rdy [DEPTH];
  logic [WIDTH-1:0] rs1_val [DEPTH];
  logic [WIDTH-1:0] rs2_val [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              start_q, start_d, op_q, op_d, pred_q, pred_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic [WIDTH-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, oimm_q, oimm_d, opc_q, opc_d;
  logic              push, issue, disp_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    logic load;
    assign load = push && (tail_q == PTR_W'(g));

    sched_operand_slot #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_rs1 (
      .i_clk(i_clk), .i_rst(i_rst), .i_load(load), .i_entry_valid(ctrl_q[g].valid),
      .i_val(i_disp_rs1_val), .i_tag(i_disp_rs1_tag), .i_rdy(i_disp_rs1_rdy),
      .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
      .o_rdy(rs1_rdy[g]), .o_val(rs1_val[g])
    );

    sched_operand_slot #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_rs2 (
      .i_clk(i_clk), .i_rst(i_rst), .i_load(load), .i_entry_valid(ctrl_q[g].valid),
      .i_val(i_disp_rs2_val), .i_tag(i_disp_rs2_tag), .i_rdy(i_disp_rs2_rdy),
      .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
      .o_rdy(rs2_rdy[g]), .o_val(rs2_val[g])
    );
  end

  always_comb begin
    // Occupancy decides full/empty; head == tail is ambiguous on its own.
    disp_ready = (count_q < CNT_W'(DEPTH)) && !i_flush;
    push       = i_disp_valid && disp_ready;
    issue      = ctrl_q[head_q].valid && rs1_rdy[head_q] && rs2_rdy[head_q] && !i_flush;

    for (int i = 0; i < DEPTH; i++) begin
      ctrl_d[i] = ctrl_q[i];
      imm_d[i]  = imm_q[i];
      pc_d[i]   = pc_q[i];
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    start_d = issue;
    op_d    = op_q;
    func_d  = func_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    oimm_d  = oimm_q;
    opc_d   = opc_q;
    pred_d  = pred_q;

    if (issue) begin
      op_d   = ctrl_q[head_q].op;
      func_d = ctrl_q[head_q].func;
      pred_d = ctrl_q[head_q].pred;
      rs1_d  = rs1_val[head_q];
      rs2_d  = rs2_val[head_q];
      oimm_d = imm_q[head_q];
      opc_d  = pc_q[head_q];
    end

    if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) ctrl_d[i].valid = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Push and issue never target the same slot: push needs a free
      // entry, issue needs the head to be occupied.
      if (issue) begin
        ctrl_d[head_q].valid = 1'b0;
        head_d               = head_q + 1'b1;
      end
      if (push) begin
        ctrl_d[tail_q] = '{valid: 1'b1, op: i_disp_op, func: i_disp_func,
                           pred: i_disp_pred};
        imm_d[tail_q]  = i_disp_imm;
        pc_d[tail_q]   = i_disp_pc;
        tail_d         = tail_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(issue);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i] <= '0;
        imm_q[i]  <= '0;
        pc_q[i]   <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      start_q <= 1'b0;
      op_q    <= 1'b0;
      func_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      oimm_q  <= '0;
      opc_q   <= '0;
      pred_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i] <= ctrl_d[i];
        imm_q[i]  <= imm_d[i];
        pc_q[i]   <= pc_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      start_q <= start_d;
      op_q    <= op_d;
      func_q  <= func_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      oimm_q  <= oimm_d;
      opc_q   <= opc_d;
      pred_q  <= pred_d;
    end
  end

  assign o_disp_ready = disp_ready;
  assign o_start      = start_q;
  assign o_op         = op_q;
  assign o_func       = func_q;
  assign o_rs1        = rs1_q;
  assign o_rs2        = rs2_q;
  assign o_imm        = oimm_q;
  assign o_pc         = opc_q;
  assign o_pred       = pred_q;
  assign o_count      = count_q;

endmodule
